mmio_io_port: RTL and testbench
===============================

# mmio_io_port

Device-side endpoint for the CPU's memory-mapped I/O words: it sources the `io_in`/`eof` pair the CPU samples when reading the input address, and sinks the `io_out` word the CPU emits when writing the output address. Two synchronous FIFOs, one per direction, decouple the single-cycle, non-stalling CPU accesses from a valid/ready host interface (testbench, UART bridge, or loader). It sits between the CPU's MMIO decode and the board or host I/O.

## Interface
- `DEPTH_LOG2`, default 4: each FIFO holds `2**DEPTH_LOG2` words.
- Data width is `` `WORD_SIZE `` from `defines.vh`, for all data ports.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `in_read` in 1: CPU consumes the input word this cycle.
- `io_in` out WORD_SIZE: current input word presented to the CPU.
- `eof` out 1: input stream has ended.
- `out_write` in 1: CPU emits `io_out` this cycle.
- `io_out` in WORD_SIZE: output word from the CPU.
- `host_in_valid` in 1: host offers `host_in_data`.
- `host_in_ready` out 1: input FIFO can accept a word.
- `host_in_data` in WORD_SIZE: input word from the host.
- `host_in_close` in 1: host pulses this to mark end of input; the state is sticky.
- `host_out_valid` out 1: output FIFO is non-empty.
- `host_out_ready` in 1: host takes `host_out_data`.
- `host_out_data` out WORD_SIZE: head of the output FIFO.
- `underrun` out 1: sticky; CPU read from an empty, unclosed input.
- `overflow` out 1: sticky; CPU write dropped because the output FIFO was full.
- `err_clear` in 1: clears `underrun` and `overflow`.

## Operation
- **Input FIFO**
  - Host push occurs when `host_in_valid && host_in_ready`.
  - `host_in_ready = !in_full`. It depends only on full, so a push is never accepted while full, even if a pop happens in the same cycle.
  - `io_in` is the FIFO head, read combinationally from registered storage. It is 0 when the FIFO is empty.
  - `in_read` while non-empty pops the head at the clock edge.
  - `in_read` while empty:
    - no pop occurs;
    - if `closed` is clear, `underrun` is set;
    - if `closed` is set, no flag is set, because the CPU halts on `eof`.
- **Close**
  - `host_in_close` sets the `closed` register.
  - `closed` is cleared only by `reset`.
  - `eof = closed && in_empty`.
  - Words pushed after close are still accepted and delivered, and `eof` drops again while they remain.
- **Output FIFO**
  - `out_write` while not full pushes `io_out`.
  - `out_write` while full drops the word and sets `overflow`. This applies even if the host pops in the same cycle.
  - `host_out_valid = !out_empty` and `host_out_data` is the head word.
  - A pop occurs when `host_out_valid && host_out_ready`.
- **Pointers**
  - Each FIFO uses read and write pointers of `DEPTH_LOG2+1` bits.
  - Empty when the pointers are equal. Full when the MSBs differ and the remaining bits are equal.
  - Pointers wrap modulo `2**(DEPTH_LOG2+1)`.
- **Simultaneous events**
  - Push and pop together on a non-empty, non-full FIFO: both take effect and the occupancy is unchanged.
  - Push and `in_read` on an empty input FIFO: the push is accepted, there is no pop, `io_in` is 0 that cycle, and the underrun rule applies.
  - `err_clear` coinciding with a new error event: the new error wins and the flag is set.

## Timing
- **Reset values**
  - Pointers are 0 and `closed` is 0.
  - `io_in=0`, `eof=0`, `host_in_ready=1`, `host_out_valid=0`, `host_out_data=0`, `underrun=0`, `overflow=0`.
- **Reset behaviour**
  - Asserting `reset` at any time, including mid-stream, immediately discards the contents of both FIFOs.
  - Release is synchronous to the next `clk` edge as seen by logic.
- **Latency**
  - A host push becomes visible on `io_in`/`eof` one cycle later.
  - A CPU `out_write` becomes visible on `host_out_valid` one cycle later.
  - `io_in` advances to the next word the cycle after a pop.
- **Combinational paths**
  - `io_in`, `eof`, `host_in_ready` and `host_out_valid` have no combinational path from any input; they are decoded from registers only.
  - `host_out_data` likewise depends on registers only.

## Configuration
- The feature is controlled by the `IO_COUNT_EN` macro.
- **Defined:** adds two output ports, each WORD_SIZE wide and reset to 0, wrapping modulo `2**WORD_SIZE`:
  - `rd_count`: increments on each successful CPU pop.
  - `wr_count`: increments on each accepted CPU write; dropped writes do not count.
- **Undefined:** the ports and counters are absent, and all other behaviour is identical.

## Test plan
- Push 0x41, 0x42, then pulse `in_read` twice → `io_in` shows 0x41 then 0x42, then 0. `eof` stays 0 until `host_in_close`, then goes to 1.
- Pulse `in_read` with the input empty and not closed → `io_in=0`, `underrun=1`. Pulse `err_clear` → `underrun=0`.
- Issue `2**DEPTH_LOG2 + 1` CPU writes of 1..17 with `host_out_ready=0` → 16 words stored and `overflow=1`. The host then drains 1..16 in order; 17 is lost.
- Fill the input FIFO, then assert `in_read` and `host_in_valid` in the same cycle → pop occurs, push is refused (`host_in_ready` was 0), occupancy is 15.
- Assert `reset` mid-stream with both FIFOs half full → all outputs take their reset values immediately, and the next words pushed are delivered with no stale data.
- With `IO_COUNT_EN` defined: 3 CPU reads and 5 writes, one of them dropped → `rd_count=3`, `wr_count=4`.

Source files
------------

// File: rtl/mmio_io_port.sv
// MMIO endpoint: input FIFO (host -> CPU io_in/eof) and output FIFO (CPU io_out -> host).
// Optional IO_COUNT_EN macro adds rd_count/wr_count transfer counters.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module mmio_io_port #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_read,
    output logic [`WORD_SIZE-1:0]  io_in,
    output logic                   eof,
    input  logic                   out_write,
    input  logic [`WORD_SIZE-1:0]  io_out,
    input  logic                   host_in_valid,
    output logic                   host_in_ready,
    input  logic [`WORD_SIZE-1:0]  host_in_data,
    input  logic                   host_in_close,
    output logic                   host_out_valid,
    input  logic                   host_out_ready,
    output logic [`WORD_SIZE-1:0]  host_out_data,
    output logic                   underrun,
    output logic                   overflow,
    input  logic                   err_clear
`ifdef IO_COUNT_EN
    ,
    output logic [`WORD_SIZE-1:0]  rd_count,
    output logic [`WORD_SIZE-1:0]  wr_count
`endif
);

    localparam int DATA_W = `WORD_SIZE;
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int PW     = DEPTH_LOG2 + 1;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    function automatic logic ptr_full(input logic [PW-1:0] w, input logic [PW-1:0] r);
        return (w[PW-1] != r[PW-1]) && (w[PW-2:0] == r[PW-2:0]);
    endfunction

    logic [DATA_W-1:0] in_mem_q  [DEPTH];
    logic [DATA_W-1:0] out_mem_q [DEPTH];

    logic [PW-1:0] in_wptr_q,  in_wptr_d,  in_rptr_q,  in_rptr_d;
    logic [PW-1:0] out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
    logic          closed_q,   closed_d;
    logic          underrun_q, underrun_d;
    logic          overflow_q, overflow_d;

    logic in_empty, in_full, out_empty, out_full;
    logic in_push, in_pop, out_push, out_pop;

    always_comb begin
        in_empty  = (in_wptr_q == in_rptr_q);
        in_full   = ptr_full(in_wptr_q, in_rptr_q);
        out_empty = (out_wptr_q == out_rptr_q);
        out_full  = ptr_full(out_wptr_q, out_rptr_q);

        // Push acceptance looks only at full, never at a same-cycle pop.
        in_push  = host_in_valid && !in_full;
        in_pop   = in_read && !in_empty;
        out_push = out_write && !out_full;
        out_pop  = host_out_ready && !out_empty;

        in_wptr_d  = in_push  ? in_wptr_q  + PW'(1) : in_wptr_q;
        in_rptr_d  = in_pop   ? in_rptr_q  + PW'(1) : in_rptr_q;
        out_wptr_d = out_push ? out_wptr_q + PW'(1) : out_wptr_q;
        out_rptr_d = out_pop  ? out_rptr_q + PW'(1) : out_rptr_q;

        closed_d = closed_q || host_in_close;

        // A new error event takes priority over err_clear.
        underrun_d = underrun_q;
        if (in_read && in_empty && !closed_q) begin
            underrun_d = 1'b1;
        end else if (err_clear) begin
            underrun_d = 1'b0;
        end

        overflow_d = overflow_q;
        if (out_write && out_full) begin
            overflow_d = 1'b1;
        end else if (err_clear) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_wptr_q  <= '0;
            in_rptr_q  <= '0;
            out_wptr_q <= '0;
            out_rptr_q <= '0;
            closed_q   <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            in_wptr_q  <= in_wptr_d;
            in_rptr_q  <= in_rptr_d;
            out_wptr_q <= out_wptr_d;
            out_rptr_q <= out_rptr_d;
            closed_q   <= closed_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (in_push) begin
            in_mem_q[in_wptr_q[DEPTH_LOG2-1:0]] <= host_in_data;
        end
        if (out_push) begin
            out_mem_q[out_wptr_q[DEPTH_LOG2-1:0]] <= io_out;
        end
    end

    assign io_in          = in_empty ? '0 : in_mem_q[in_rptr_q[DEPTH_LOG2-1:0]];
    assign eof            = closed_q && in_empty;
    assign host_in_ready  = !in_full;
    assign host_out_valid = !out_empty;
    assign host_out_data  = out_empty ? '0 : out_mem_q[out_rptr_q[DEPTH_LOG2-1:0]];
    assign underrun       = underrun_q;
    assign overflow       = overflow_q;

`ifdef IO_COUNT_EN
    logic [DATA_W-1:0] rd_count_q, rd_count_d;
    logic [DATA_W-1:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = in_pop   ? rd_count_q + DATA_W'(1) : rd_count_q;
        wr_count_d = out_push ? wr_count_q + DATA_W'(1) : wr_count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_mmio_io_port.sv
// Self-checking bench for mmio_io_port: directed scenarios plus a randomized run
// against a queue-based reference model.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module tb_mmio_io_port;

    localparam int W     = `WORD_SIZE;
    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;

    logic         clk;
    logic         reset;
    logic         in_read;
    logic [W-1:0] io_in;
    logic         eof;
    logic         out_write;
    logic [W-1:0] io_out;
    logic         host_in_valid;
    logic         host_in_ready;
    logic [W-1:0] host_in_data;
    logic         host_in_close;
    logic         host_out_valid;
    logic         host_out_ready;
    logic [W-1:0] host_out_data;
    logic         underrun;
    logic         overflow;
    logic         err_clear;
`ifdef IO_COUNT_EN
    logic [W-1:0] rd_count;
    logic [W-1:0] wr_count;
`endif

    int checks   = 0;
    int failures = 0;

    mmio_io_port #(.DEPTH_LOG2(DL2)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_read        (in_read),
        .io_in          (io_in),
        .eof            (eof),
        .out_write      (out_write),
        .io_out         (io_out),
        .host_in_valid  (host_in_valid),
        .host_in_ready  (host_in_ready),
        .host_in_data   (host_in_data),
        .host_in_close  (host_in_close),
        .host_out_valid (host_out_valid),
        .host_out_ready (host_out_ready),
        .host_out_data  (host_out_data),
        .underrun       (underrun),
        .overflow       (overflow),
        .err_clear      (err_clear)
`ifdef IO_COUNT_EN
        ,
        .rd_count       (rd_count),
        .wr_count       (wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        in_read        = 1'b0;
        out_write      = 1'b0;
        io_out         = '0;
        host_in_valid  = 1'b0;
        host_in_data   = '0;
        host_in_close  = 1'b0;
        host_out_ready = 1'b0;
        err_clear      = 1'b0;
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        #1;
        checks++; if (io_in !== '0) begin failures++; $display("FAIL rst_io_in got=%h exp=0", io_in); end
        checks++; if (eof !== 1'b0) begin failures++; $display("FAIL rst_eof got=%b exp=0", eof); end
        checks++; if (host_in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", host_in_ready); end
        checks++; if (host_out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", host_out_valid); end
        checks++; if (host_out_data !== '0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", host_out_data); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL rst_underrun got=%b exp=0", underrun); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
`ifdef IO_COUNT_EN
        checks++; if (rd_count !== '0 || wr_count !== '0) begin failures++; $display("FAIL rst_counts got=%h/%h exp=0/0", rd_count, wr_count); end
`endif
        @(negedge clk);
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_input_basic();
        do_reset();
        host_in_valid = 1'b1; host_in_data = W'(8'h41);
        cyc();
        checks++; if (io_in !== W'(8'h41)) begin failures++; $display("FAIL in_latency got=%h exp=41", io_in); end
        host_in_data = W'(8'h42);
        cyc();
        host_in_valid = 1'b0;
        checks++; if (eof !== 1'b0) begin failures++; $display("FAIL in_eof_open got=%b exp=0", eof); end
        in_read = 1'b1;
        cyc();
        in_read = 1'b0;
        checks++; if (io_in !== W'(8'h42)) begin failures++; $display("FAIL in_second got=%h exp=42", io_in); end
        in_read = 1'b1;
        cyc();
        in_read = 1'b0;
        checks++; if (io_in !== '0) begin failures++; $display("FAIL in_empty got=%h exp=0", io_in); end
        checks++; if (eof !== 1'b0) begin failures++; $display("FAIL in_eof_unclosed got=%b exp=0", eof); end
        host_in_close = 1'b1;
        cyc();
        host_in_close = 1'b0;
        checks++; if (eof !== 1'b1) begin failures++; $display("FAIL in_eof_closed got=%b exp=1", eof); end
        in_read = 1'b1;
        cyc();
        in_read = 1'b0;
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL in_closed_no_underrun got=%b exp=0", underrun); end
        host_in_valid = 1'b1; host_in_data = W'(8'h55);
        cyc();
        host_in_valid = 1'b0;
        checks++; if (eof !== 1'b0 || io_in !== W'(8'h55)) begin failures++; $display("FAIL in_after_close got=%b/%h exp=0/55", eof, io_in); end
        in_read = 1'b1;
        cyc();
        in_read = 1'b0;
        checks++; if (eof !== 1'b1) begin failures++; $display("FAIL in_eof_again got=%b exp=1", eof); end
    endtask

    task automatic test_underrun();
        do_reset();
        in_read = 1'b1;
        cyc();
        in_read = 1'b0;
        checks++; if (io_in !== '0 || underrun !== 1'b1) begin failures++; $display("FAIL underrun_set got=%h/%b exp=0/1", io_in, underrun); end
        err_clear = 1'b1;
        cyc();
        err_clear = 1'b0;
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL underrun_clear got=%b exp=0", underrun); end
        in_read = 1'b1; err_clear = 1'b1;
        cyc();
        in_read = 1'b0; err_clear = 1'b0;
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL underrun_wins got=%b exp=1", underrun); end
        do_reset();
        host_in_valid = 1'b1; host_in_data = W'(8'h77); in_read = 1'b1;
        #1;
        checks++; if (io_in !== '0) begin failures++; $display("FAIL push_read_empty_io got=%h exp=0", io_in); end
        cyc();
        host_in_valid = 1'b0; in_read = 1'b0;
        checks++; if (io_in !== W'(8'h77) || underrun !== 1'b1) begin failures++; $display("FAIL push_read_empty got=%h/%b exp=77/1", io_in, underrun); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= DEPTH + 1; i++) begin
            out_write = 1'b1; io_out = W'(i);
            cyc();
            if (i == 1) begin
                checks++; if (host_out_valid !== 1'b1 || host_out_data !== W'(1)) begin failures++; $display("FAIL out_latency got=%b/%h exp=1/1", host_out_valid, host_out_data); end
            end
        end
        out_write = 1'b0;
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        host_out_ready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            checks++; if (host_out_valid !== 1'b1 || host_out_data !== W'(i)) begin failures++; $display("FAIL out_drain[%0d] got=%b/%h exp=1/%h", i, host_out_valid, host_out_data, W'(i)); end
            cyc();
        end
        host_out_ready = 1'b0;
        checks++; if (host_out_valid !== 1'b0 || host_out_data !== '0) begin failures++; $display("FAIL out_drained got=%b/%h exp=0/0", host_out_valid, host_out_data); end
        err_clear = 1'b1;
        cyc();
        err_clear = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        for (int i = 1; i <= DEPTH; i++) begin
            out_write = 1'b1; io_out = W'(100 + i);
            cyc();
        end
        io_out = W'(16'hEE); host_out_ready = 1'b1;
        cyc();
        out_write = 1'b0;
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_with_pop got=%b exp=1", overflow); end
        for (int i = 2; i <= DEPTH; i++) begin
            checks++; if (host_out_data !== W'(100 + i)) begin failures++; $display("FAIL ovf_pop_drain[%0d] got=%h exp=%h", i, host_out_data, W'(100 + i)); end
            cyc();
        end
        host_out_ready = 1'b0;
        checks++; if (host_out_valid !== 1'b0) begin failures++; $display("FAIL ovf_dropped_word got=%b exp=0", host_out_valid); end
    endtask

    task automatic test_full_simul();
        int n;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            host_in_valid = 1'b1; host_in_data = W'(16 + i);
            cyc();
        end
        checks++; if (host_in_ready !== 1'b0) begin failures++; $display("FAIL in_full_ready got=%b exp=0", host_in_ready); end
        host_in_data = W'(8'hAA); in_read = 1'b1;
        cyc();
        host_in_valid = 1'b0; in_read = 1'b0;
        checks++; if (host_in_ready !== 1'b1 || io_in !== W'(17)) begin failures++; $display("FAIL full_pop got=%b/%h exp=1/11", host_in_ready, io_in); end
        n = 0;
        in_read = 1'b1;
        for (int k = 0; k < DEPTH + 2; k++) begin
            if (io_in != '0) begin
                checks++; if (io_in !== W'(17 + n)) begin failures++; $display("FAIL full_drain[%0d] got=%h exp=%h", n, io_in, W'(17 + n)); end
                n++;
            end
            cyc();
        end
        in_read = 1'b0;
        checks++; if (n !== DEPTH - 1) begin failures++; $display("FAIL full_occupancy got=%0d exp=%0d", n, DEPTH - 1); end
    endtask

    task automatic test_midstream_reset();
        do_reset();
        in_read = 1'b1;
        cyc();
        in_read = 1'b0;
        for (int i = 0; i < DEPTH / 2; i++) begin
            host_in_valid = 1'b1; host_in_data = W'(200 + i);
            out_write = 1'b1; io_out = W'(300 + i);
            cyc();
        end
        idle();
        host_in_close = 1'b1;
        cyc();
        host_in_close = 1'b0;
        checks++; if (io_in !== W'(200) || underrun !== 1'b1) begin failures++; $display("FAIL pre_reset got=%h/%b exp=c8/1", io_in, underrun); end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (io_in !== '0 || eof !== 1'b0 || host_in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in got=%h/%b/%b exp=0/0/1", io_in, eof, host_in_ready); end
        checks++; if (host_out_valid !== 1'b0 || host_out_data !== '0) begin failures++; $display("FAIL midrst_out got=%b/%h exp=0/0", host_out_valid, host_out_data); end
        checks++; if (underrun !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL midrst_flags got=%b/%b exp=0/0", underrun, overflow); end
        @(negedge clk);
        reset = 1'b0;
        host_in_valid = 1'b1; host_in_data = W'(8'h99);
        out_write = 1'b1; io_out = W'(8'h5A);
        cyc();
        idle();
        checks++; if (io_in !== W'(8'h99) || host_out_data !== W'(8'h5A)) begin failures++; $display("FAIL postrst_word got=%h/%h exp=99/5a", io_in, host_out_data); end
        in_read = 1'b1; host_out_ready = 1'b1;
        cyc();
        idle();
        checks++; if (io_in !== '0 || host_out_valid !== 1'b0 || eof !== 1'b0) begin failures++; $display("FAIL postrst_stale got=%h/%b/%b exp=0/0/0", io_in, host_out_valid, eof); end
    endtask

`ifdef IO_COUNT_EN
    task automatic test_counters();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            host_in_valid = 1'b1; host_in_data = W'(i + 1);
            cyc();
        end
        host_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_read = 1'b1;
            cyc();
        end
        in_read = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            out_write = 1'b1; io_out = W'(i);
            cyc();
        end
        out_write = 1'b0;
        checks++; if (rd_count !== W'(3)) begin failures++; $display("FAIL rd_count got=%0d exp=3", rd_count); end
        checks++; if (wr_count !== W'(DEPTH)) begin failures++; $display("FAIL wr_count got=%0d exp=%0d", wr_count, DEPTH); end
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] inq[$];
        logic [W-1:0] outq[$];
        logic m_closed, m_under, m_over;
        logic [W-1:0] m_rd, m_wr;
        logic [W-1:0] e_io_in, e_out_data;
        logic in_was_empty, in_was_full, out_was_empty, out_was_full;
        do_reset();
        m_closed = 1'b0; m_under = 1'b0; m_over = 1'b0;
        m_rd = '0; m_wr = '0;
        for (int c = 0; c < 600; c++) begin
            host_in_valid  = ($urandom_range(99) < 50);
            host_in_data   = W'($urandom);
            in_read        = ($urandom_range(99) < 45);
            out_write      = ($urandom_range(99) < 50);
            io_out         = W'($urandom);
            host_out_ready = ($urandom_range(99) < 45);
            host_in_close  = ($urandom_range(99) < 2);
            err_clear      = ($urandom_range(99) < 6);
            e_io_in    = (inq.size() == 0)  ? '0 : inq[0];
            e_out_data = (outq.size() == 0) ? '0 : outq[0];
            checks++; if (io_in !== e_io_in) begin failures++; $display("FAIL rnd_io_in c=%0d got=%h exp=%h", c, io_in, e_io_in); end
            checks++; if (eof !== (m_closed && inq.size() == 0)) begin failures++; $display("FAIL rnd_eof c=%0d got=%b", c, eof); end
            checks++; if (host_in_ready !== (inq.size() < DEPTH)) begin failures++; $display("FAIL rnd_in_ready c=%0d got=%b size=%0d", c, host_in_ready, inq.size()); end
            checks++; if (host_out_valid !== (outq.size() != 0) || host_out_data !== e_out_data) begin failures++; $display("FAIL rnd_out c=%0d got=%b/%h exp=%h", c, host_out_valid, host_out_data, e_out_data); end
            checks++; if (underrun !== m_under || overflow !== m_over) begin failures++; $display("FAIL rnd_flags c=%0d got=%b/%b exp=%b/%b", c, underrun, overflow, m_under, m_over); end
`ifdef IO_COUNT_EN
            checks++; if (rd_count !== m_rd || wr_count !== m_wr) begin failures++; $display("FAIL rnd_counts c=%0d got=%0d/%0d exp=%0d/%0d", c, rd_count, wr_count, m_rd, m_wr); end
`endif
            in_was_empty  = (inq.size() == 0);
            in_was_full   = (inq.size() == DEPTH);
            out_was_empty = (outq.size() == 0);
            out_was_full  = (outq.size() == DEPTH);
            if (in_read && !in_was_empty) begin
                void'(inq.pop_front());
                m_rd = m_rd + W'(1);
            end
            if (host_in_valid && !in_was_full) inq.push_back(host_in_data);
            if (in_read && in_was_empty && !m_closed) m_under = 1'b1;
            else if (err_clear) m_under = 1'b0;
            if (host_out_ready && !out_was_empty) void'(outq.pop_front());
            if (out_write && !out_was_full) begin
                outq.push_back(io_out);
                m_wr = m_wr + W'(1);
            end
            if (out_write && out_was_full) m_over = 1'b1;
            else if (err_clear) m_over = 1'b0;
            if (host_in_close) m_closed = 1'b1;
            cyc();
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        cyc();
        test_reset();
        test_input_basic();
        test_underrun();
        test_overflow();
        test_full_simul();
        test_midstream_reset();
`ifdef IO_COUNT_EN
        test_counters();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
